// File: rtl/ct_seq_multiplier_taint.sv
// Constant-time shift-add multiplier with bitwise taint shadow logic.
// Every job runs exactly WIDTH iterations, so control taint follows only the handshake.
module ct_seq_multiplier_taint #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 start_t,
    input  logic                 ack,
    input  logic                 ack_t,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplicand_t,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplier_t,
    output logic                 busy,
    output logic                 busy_t,
    output logic                 done,
    output logic                 done_t,
    output logic [2*WIDTH-1:0]   product,
    output logic [2*WIDTH-1:0]   product_t
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   md_q, md_t_q, mr_q, mr_t_q;
    logic [PW-1:0]      acc_q, acc_t_q;
    logic [PW-1:0]      product_q, product_t_q;
    logic               ctl_t_q, busy_q, done_q;

    logic               bit_m, bit_t;
    logic [PW-1:0]      addend, t_i, tsum;
    logic [PW-1:0]      acc_d, acc_t_d;

    // The add runs every CALC cycle; a cleared multiplier bit only zeroes the addend.
    always_comb begin
        bit_m   = mr_q[cnt_q];
        bit_t   = mr_t_q[cnt_q];
        addend  = bit_m ? (PW'(md_q) << cnt_q) : '0;
        acc_d   = acc_q + addend;
        if (bit_t) begin
            t_i = {PW{1'b1}} << cnt_q;
        end else if (bit_m) begin
            t_i = PW'(md_t_q) << cnt_q;
        end else begin
            t_i = '0;
        end
        tsum    = acc_t_q | t_i;
        // Carry can ripple upward from the lowest tainted bit.
        acc_t_d = '0;
        acc_t_d[0] = tsum[0];
        for (int unsigned k = 1; k < PW; k++) begin
            acc_t_d[k] = acc_t_d[k-1] | tsum[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            md_q        <= '0;
            md_t_q      <= '0;
            mr_q        <= '0;
            mr_t_q      <= '0;
            acc_q       <= '0;
            acc_t_q     <= '0;
            product_q   <= '0;
            product_t_q <= '0;
            ctl_t_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ctl_t_q <= start_t;
                    if (start) begin
                        md_q    <= multiplicand;
                        md_t_q  <= multiplicand_t;
                        mr_q    <= multiplier;
                        mr_t_q  <= multiplier_t;
                        acc_q   <= '0;
                        acc_t_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q   <= acc_d;
                    acc_t_q <= acc_t_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        product_q   <= acc_d;
                        product_t_q <= acc_t_d;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    ctl_t_q <= ctl_t_q | ack_t;
                    if (ack) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign busy_t    = ctl_t_q;
    assign done_t    = ctl_t_q;
    assign product   = product_q;
    assign product_t = product_t_q;

endmodule

// File: tb/tb_ct_seq_multiplier_taint.sv
// Bench for ct_seq_multiplier_taint: fixed vectors, handshake corners, reset abort, random jobs.
module tb_ct_seq_multiplier_taint;

    localparam int unsigned W = 8;
    localparam int unsigned P = 16;

    logic         clk = 1'b0;
    logic         rst, start, start_t, ack, ack_t;
    logic [W-1:0] multiplicand, multiplicand_t, multiplier, multiplier_t;
    logic         busy, busy_t, done, done_t;
    logic [P-1:0] product, product_t;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ct_seq_multiplier_taint #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_t        (start_t),
        .ack            (ack),
        .ack_t          (ack_t),
        .multiplicand   (multiplicand),
        .multiplicand_t (multiplicand_t),
        .multiplier     (multiplier),
        .multiplier_t   (multiplier_t),
        .busy           (busy),
        .busy_t         (busy_t),
        .done           (done),
        .done_t         (done_t),
        .product        (product),
        .product_t      (product_t)
    );

    typedef struct {
        logic [W-1:0] a, at, b, bt;
        logic         st;
        logic [P-1:0] ep, ept;
        int           glitch;
        int           hold;
        logic         hold_ackt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Product taint covers every bit at or above the lowest position any tainted
    // partial product can reach.
    function automatic logic [P-1:0] ref_taint(input logic [W-1:0] at, b, bt);
        int lo = P;
        int la = P;
        for (int j = W - 1; j >= 0; j--) if (at[j]) la = j;
        for (int i = 0; i < W; i++) begin
            if (bt[i]) begin
                if (i < lo) lo = i;
            end else if (b[i] && la < P) begin
                if (i + la < lo) lo = i + la;
            end
        end
        if (lo >= P) return '0;
        return 16'hFFFF << lo;
    endfunction

    task automatic run_job(input vec_t v, input string tag);
        int   n = 0;
        int   busy_cnt = 0;
        logic exp_ctl;
        multiplicand   = v.a;
        multiplicand_t = v.at;
        multiplier     = v.b;
        multiplier_t   = v.bt;
        start          = 1'b1;
        start_t        = v.st;
        step();
        check({tag, " busy_t"}, busy_t, v.st);
        while (!done && n < 4 * W) begin
            if (busy) busy_cnt++;
            start   = (n == v.glitch);
            start_t = 1'($urandom);
            ack     = 1'($urandom);
            ack_t   = 1'($urandom);
            if (n == v.glitch) begin
                multiplicand = ~v.a;
                multiplier   = ~v.b;
            end
            step();
            n++;
        end
        start   = 1'b0;
        start_t = 1'b0;
        check({tag, " latency"}, n, W);
        check({tag, " busy_cycles"}, busy_cnt, W);
        check({tag, " product"}, product, v.ep);
        check({tag, " product_t"}, product_t, v.ept);
        check({tag, " done_t"}, done_t, v.st);
        exp_ctl = v.st;
        for (int h = 0; h < v.hold; h++) begin
            ack   = 1'b0;
            ack_t = v.hold_ackt;
            step();
            exp_ctl = exp_ctl | v.hold_ackt;
            check({tag, " hold_done"}, done, 1'b1);
            check({tag, " hold_product"}, product, v.ep);
            check({tag, " hold_done_t"}, done_t, exp_ctl);
        end
        ack   = 1'b1;
        ack_t = 1'b0;
        step();
        ack = 1'b0;
        check({tag, " done_after_ack"}, done, 1'b0);
        check({tag, " busy_after_ack"}, busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vec_t rv;

        vecs[0] = '{8'd13,  8'h00, 8'd11,  8'h00, 1'b0, 16'h008F, 16'h0000, -1, 0, 1'b0};
        vecs[1] = '{8'd255, 8'h00, 8'd255, 8'h00, 1'b0, 16'hFE01, 16'h0000, -1, 0, 1'b0};
        vecs[2] = '{8'd255, 8'h00, 8'd0,   8'h00, 1'b0, 16'h0000, 16'h0000, -1, 0, 1'b0};
        vecs[3] = '{8'd3,   8'h80, 8'h01,  8'h00, 1'b0, 16'h0003, 16'hFF80, -1, 0, 1'b0};
        vecs[4] = '{8'd3,   8'h80, 8'h02,  8'h00, 1'b0, 16'h0006, 16'hFF00, -1, 0, 1'b0};
        vecs[5] = '{8'd3,   8'h80, 8'h00,  8'h00, 1'b0, 16'h0000, 16'h0000, -1, 0, 1'b0};
        vecs[6] = '{8'd5,   8'h00, 8'd6,   8'h10, 1'b0, 16'h001E, 16'hFFF0, -1, 0, 1'b0};
        vecs[7] = '{8'd13,  8'h00, 8'd11,  8'h00, 1'b1, 16'h008F, 16'h0000, -1, 3, 1'b0};
        vecs[8] = '{8'd9,   8'h00, 8'd7,   8'h00, 1'b0, 16'h003F, 16'h0000, -1, 2, 1'b1};
        vecs[9] = '{8'd5,   8'h00, 8'd6,   8'h10, 1'b0, 16'h001E, 16'hFFF0,  3, 0, 1'b0};

        rst = 1'b1;
        start = 1'b0; start_t = 1'b0; ack = 1'b0; ack_t = 1'b0;
        multiplicand = '0; multiplicand_t = '0; multiplier = '0; multiplier_t = '0;
        step();
        step();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset busy_t", busy_t, 1'b0);
        check("reset done_t", done_t, 1'b0);
        check("reset product", product, 16'h0000);
        check("reset product_t", product_t, 16'h0000);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // start taint is sampled in IDLE even without a start
        start_t = 1'b1;
        step();
        check("idle busy_t", busy_t, 1'b1);
        check("idle busy", busy, 1'b0);
        start_t = 1'b0;
        step();
        check("idle busy_t clear", busy_t, 1'b0);

        // reset in the fourth CALC cycle aborts the job
        multiplicand = 8'd200; multiplier = 8'd100;
        multiplicand_t = 8'h01; multiplier_t = 8'h00;
        start = 1'b1; start_t = 1'b1;
        step();
        start = 1'b0; start_t = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("abort busy before rst", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort product", product, 16'h0000);
        check("abort product_t", product_t, 16'h0000);
        check("abort busy_t", busy_t, 1'b0);
        run_job(vecs[0], "post_abort");

        for (int r = 0; r < 40; r++) begin
            rv.a  = 8'($urandom);
            rv.b  = 8'($urandom);
            rv.at = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            rv.bt = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            rv.st = 1'($urandom);
            rv.ep = 16'({8'h00, rv.a} * {8'h00, rv.b});
            rv.ept = ref_taint(rv.at, rv.b, rv.bt);
            rv.glitch = ($urandom_range(4) == 0) ? int'($urandom_range(W - 1)) : -1;
            rv.hold = int'($urandom_range(2));
            rv.hold_ackt = 1'($urandom);
            run_job(rv, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
